or1200_secure_supv_gen: RTL

//  Owns the tamper-resistant 3-bit supervisor-mode encoding (supv = XOR of bits) consumed by the privilege checker.

---
 rtl/or1200_secure_supv_gen_pkg.sv | 49 ++++
 rtl/or1200_checker_lfsr.sv | 28 ++
 rtl/or1200_secure_supv_gen.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/or1200_secure_supv_gen_pkg.sv
// Shared constants, types and helper functions for the secure supervisor-mode
// encoding and the checker LFSR family.
package or1200_secure_supv_gen_pkg;

    // Encoded mode after reset: odd parity, so the core starts in supervisor mode
    localparam logic [2:0]  SSUPV_RST         = 3'b001;

    // Galois mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Odd-parity codes mean supervisor, even-parity codes mean user.
    // Entry [0] is the rightmost element of each concatenation.
    localparam logic [3:0][2:0] ENC_SUPV = {3'b111, 3'b100, 3'b010, 3'b001};
    localparam logic [3:0][2:0] ENC_USER = {3'b110, 3'b101, 3'b011, 3'b000};

    // Which source updates secure_supv in a given cycle
    typedef enum logic [2:0] {
        UPD_NONE   = 3'd0,
        UPD_EXCEPT = 3'd1,
        UPD_RFE    = 3'd2,
        UPD_SR     = 3'd3,
        UPD_ROTATE = 3'd4
    } supv_upd_e;

    // Decoded mode of an encoded value
    function automatic logic ssupv_parity(input logic [2:0] code);
        return ^code;
    endfunction

    // Pick a code of the requested mode using the two LFSR low bits; if that
    // code matches the current value, step to the next table entry so every
    // update visibly changes the stored pattern.
    function automatic logic [2:0] ssupv_enc(input logic        mode,
                                             input logic [15:0] rnd,
                                             input logic [2:0]  cur);
        logic [1:0] idx;
        logic [1:0] idx_next;
        logic [2:0] code;
        idx      = rnd[1:0];
        idx_next = idx + 2'd1;
        code     = mode ? ENC_SUPV[idx] : ENC_USER[idx];
        if (code == cur) begin
            code = mode ? ENC_SUPV[idx_next] : ENC_USER[idx_next];
        end
        return code;
    endfunction

endpackage

// File: rtl/or1200_checker_lfsr.sv
// 16-bit Galois LFSR shared by the checker blocks. A zero seed would lock the
// register at zero, so it is replaced by the default seed.
module or1200_checker_lfsr
    import or1200_secure_supv_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] seed_s;
    logic [15:0] lfsr_r;

    assign seed_s = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;

    // Load the seed on reset, otherwise shift right and fold in the taps
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= seed_s;
        end else begin
            lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign q = lfsr_r;

endmodule

// File: rtl/or1200_secure_supv_gen.sv
// Owner of the 3-bit parity-encoded supervisor mode. Updates the code on
// exception entry, l.rfe and SR/ESR writes, re-encodes it periodically with
// the same parity, and raises a sticky alarm on privilege violations or when
// the encoded value disagrees with its plain shadow bit.
module or1200_secure_supv_gen
    import or1200_secure_supv_gen_pkg::*;
#(
    parameter int unsigned ROTATE_PERIOD = 64,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       except_start,
    input  logic       rfe,
    input  logic       sr_we,
    input  logic       sr_supv_wdata,
    input  logic       esr_we,
    input  logic       esr_supv_wdata,
    output logic [2:0] secure_supv,
    output logic [2:0] esr_secure_supv,
    output logic       supv_o,
    output logic       priv_violation,
    output logic       tamper_alarm,
    output logic [7:0] violation_cnt
);

    localparam bit          ROT_EN     = (ROTATE_PERIOD != 0);
    localparam int unsigned ROT_W      = (ROTATE_PERIOD > 1) ? $clog2(ROTATE_PERIOD) : 1;
    localparam int unsigned ROT_LAST_I = ROT_EN ? (ROTATE_PERIOD - 1) : 0;
    localparam logic [ROT_W-1:0] ROT_LAST = ROT_LAST_I[ROT_W-1:0];

    logic [2:0]       secure_supv_r;
    logic [2:0]       esr_secure_supv_r;
    logic             shadow_r;
    logic             esr_shadow_r;
    logic             priv_violation_r;
    logic             tamper_alarm_r;
    logic [7:0]       violation_cnt_r;
    logic [ROT_W-1:0] rot_cnt_r;

    logic [15:0]      lfsr_s;
    logic             supv_s;
    logic             rot_wrap_s;
    supv_upd_e        upd_sel_s;
    logic [2:0]       secure_nxt_s;
    logic             shadow_nxt_s;
    logic [2:0]       esr_nxt_s;
    logic             esr_shadow_nxt_s;
    logic             sr_viol_s;
    logic             esr_viol_s;
    logic             viol_s;
    logic             mismatch_s;
    logic [ROT_W-1:0] rot_nxt_s;

    or1200_checker_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr_s)
    );

    assign supv_s     = ssupv_parity(secure_supv_r);
    assign rot_wrap_s = ROT_EN && (rot_cnt_r == ROT_LAST);

    // Pick the single source allowed to update secure_supv this cycle
    always_comb begin
        upd_sel_s = UPD_NONE;
        if (except_start) begin
            upd_sel_s = UPD_EXCEPT;
        end else if (rfe) begin
            upd_sel_s = UPD_RFE;
        end else if (sr_we) begin
            upd_sel_s = UPD_SR;
        end else if (rot_wrap_s) begin
            upd_sel_s = UPD_ROTATE;
        end else begin
            upd_sel_s = UPD_NONE;
        end
    end

    // Next encoded mode and shadow bit for the selected source
    always_comb begin
        secure_nxt_s = secure_supv_r;
        shadow_nxt_s = shadow_r;
        sr_viol_s    = 1'b0;
        case (upd_sel_s)
            UPD_EXCEPT: begin
                secure_nxt_s = ssupv_enc(1'b1, lfsr_s, secure_supv_r);
                shadow_nxt_s = 1'b1;
            end
            UPD_RFE: begin
                secure_nxt_s = ssupv_enc(ssupv_parity(esr_secure_supv_r), lfsr_s, secure_supv_r);
                shadow_nxt_s = ssupv_parity(esr_secure_supv_r);
            end
            UPD_SR: begin
                if (supv_s) begin
                    secure_nxt_s = ssupv_enc(sr_supv_wdata, lfsr_s, secure_supv_r);
                    shadow_nxt_s = sr_supv_wdata;
                end else begin
                    sr_viol_s    = 1'b1;
                end
            end
            UPD_ROTATE: begin
                secure_nxt_s = ssupv_enc(supv_s, lfsr_s, secure_supv_r);
            end
            default: begin
                secure_nxt_s = secure_supv_r;
                shadow_nxt_s = shadow_r;
            end
        endcase
    end

    // ESR copy: exception entry saves the live code verbatim and overrides any write
    always_comb begin
        esr_nxt_s        = esr_secure_supv_r;
        esr_shadow_nxt_s = esr_shadow_r;
        esr_viol_s       = 1'b0;
        if (except_start) begin
            esr_nxt_s        = secure_supv_r;
            esr_shadow_nxt_s = shadow_r;
        end else if (esr_we) begin
            if (supv_s) begin
                esr_nxt_s        = ssupv_enc(esr_supv_wdata, lfsr_s, esr_secure_supv_r);
                esr_shadow_nxt_s = esr_supv_wdata;
            end else begin
                esr_viol_s = 1'b1;
            end
        end else begin
            esr_nxt_s        = esr_secure_supv_r;
            esr_shadow_nxt_s = esr_shadow_r;
        end
    end

    // Violation, shadow cross-check and free-running rotation counter
    always_comb begin
        viol_s     = sr_viol_s | esr_viol_s;
        mismatch_s = (ssupv_parity(secure_supv_r) != shadow_r) |
                     (ssupv_parity(esr_secure_supv_r) != esr_shadow_r);
        if (!ROT_EN || rot_wrap_s) begin
            rot_nxt_s = {ROT_W{1'b0}};
        end else begin
            rot_nxt_s = rot_cnt_r + ROT_W'(1'b1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            secure_supv_r     <= SSUPV_RST;
            esr_secure_supv_r <= SSUPV_RST;
            shadow_r          <= 1'b1;
            esr_shadow_r      <= 1'b1;
            priv_violation_r  <= 1'b0;
            tamper_alarm_r    <= 1'b0;
            violation_cnt_r   <= 8'h00;
            rot_cnt_r         <= {ROT_W{1'b0}};
        end else begin
            secure_supv_r     <= secure_nxt_s;
            esr_secure_supv_r <= esr_nxt_s;
            shadow_r          <= shadow_nxt_s;
            esr_shadow_r      <= esr_shadow_nxt_s;
            priv_violation_r  <= viol_s;
            tamper_alarm_r    <= tamper_alarm_r | viol_s | mismatch_s;
            rot_cnt_r         <= rot_nxt_s;
            if (viol_s && (violation_cnt_r != 8'hFF)) begin
                violation_cnt_r <= violation_cnt_r + 8'd1;
            end else begin
                violation_cnt_r <= violation_cnt_r;
            end
        end
    end

    assign secure_supv     = secure_supv_r;
    assign esr_secure_supv = esr_secure_supv_r;
    assign supv_o          = supv_s;
    assign priv_violation  = priv_violation_r;
    assign tamper_alarm    = tamper_alarm_r;
    assign violation_cnt   = violation_cnt_r;

endmodule
